// File: rtl/ftoi_converter_param.sv
// Pipelined float-to-integer converter, any EXP_W/MAN_W float to INT_W int.
// Stage 1 aligns the significand; stage 2 rounds, range-checks and negates.
module ftoi_converter_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  input  logic                   is_signed,
  input  logic [2:0]             rm,
  input  logic [EXP_W+MAN_W:0]   a,
  output logic [INT_W-1:0]       int_out,
  output logic                   IV,
  output logic                   IE
);

  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int BW   = 2 * INT_W + MAN_W + 1;

  localparam logic [INT_W:0] HALF =
    {2'b01, {(INT_W - 1){1'b0}}};
  localparam logic [INT_W-1:0] SMAX =
    {1'b0, {(INT_W - 1){1'b1}}};
  localparam logic [INT_W-1:0] SMIN =
    {1'b1, {(INT_W - 1){1'b0}}};

  logic             w_sgn;
  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;
  logic             w_exp_one;
  logic             w_exp_zero;
  logic             w_hid;
  logic             w_nan;
  logic             w_inf;
  logic signed [31:0] w_e;
  logic signed [31:0] w_sh;
  logic             w_povf;
  logic             w_tiny;
  logic [BW-1:0]    w_big;
  logic [INT_W-1:0] w_mag;
  logic             w_rnd;
  logic             w_stk;

  assign w_sgn      = a[EXP_W+MAN_W];
  assign w_exp      = a[EXP_W+MAN_W-1:MAN_W];
  assign w_man      = a[MAN_W-1:0];
  assign w_exp_one  = &w_exp;
  assign w_exp_zero = ~|w_exp;
  assign w_hid      = ~w_exp_zero;
  assign w_nan      = w_exp_one & (|w_man);
  assign w_inf      = w_exp_one & ~(|w_man);

  assign w_e = w_exp_zero ? 32'sd1 - BIAS :
    $signed({{(32 - EXP_W){1'b0}}, w_exp}) - BIAS;

  assign w_povf = w_e >= INT_W;
  assign w_tiny = w_e < -1;
  assign w_sh   = INT_W - 1 - w_e;

  // MSB starts at 2^(INT_W-1); shifting by w_sh puts it at 2^e
  assign w_big =
    {w_hid, w_man, {(2 * INT_W){1'b0}}} >> w_sh;

  // Below 2^-1 the round bit is always clear; only sticky survives
  always_comb begin
    w_mag = '0;
    w_rnd = 1'b0;
    w_stk = 1'b0;
    if (w_tiny) begin
      w_stk = w_hid | (|w_man);
    end else begin
      w_mag = w_big[BW-1 -: INT_W];
      w_rnd = w_big[BW-INT_W-1];
      w_stk = |w_big[BW-INT_W-2:0];
    end
  end

  logic             r1_valid;
  logic [INT_W-1:0] r1_mag;
  logic             r1_rnd;
  logic             r1_stk;
  logic             r1_sgn;
  logic [2:0]       r1_rm;
  logic             r1_sgd;
  logic             r1_nan;
  logic             r1_inf;
  logic             r1_povf;
  logic             r2_valid;

  logic w_adv;
  logic w_acc;

  assign valid_out = r2_valid;
  assign w_adv     = ~r2_valid | ready_in;
  assign ready_out = ~r1_valid | w_adv;
  assign w_acc     = valid_in & ready_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_valid <= 1'b0;
      r1_mag   <= '0;
      r1_rnd   <= 1'b0;
      r1_stk   <= 1'b0;
      r1_sgn   <= 1'b0;
      r1_rm    <= 3'b000;
      r1_sgd   <= 1'b0;
      r1_nan   <= 1'b0;
      r1_inf   <= 1'b0;
      r1_povf  <= 1'b0;
    end else if (flush) begin
      r1_valid <= 1'b0;
    end else begin
      if (ready_out) r1_valid <= valid_in;
      if (w_acc) begin
        r1_mag  <= w_mag;
        r1_rnd  <= w_rnd;
        r1_stk  <= w_stk;
        r1_sgn  <= w_sgn;
        r1_rm   <= rm;
        r1_sgd  <= is_signed;
        r1_nan  <= w_nan;
        r1_inf  <= w_inf;
        r1_povf <= w_povf;
      end
    end
  end

  logic             w_inc;
  logic [INT_W:0]   w_rmag;
  logic             w_inx;
  logic             w_fit;
  logic [INT_W-1:0] w_pmax;
  logic [INT_W-1:0] w_nmin;
  logic [INT_W-1:0] w_res;
  logic             w_iv;
  logic             w_ie;

  always_comb begin
    w_inc = 1'b0;
    case (r1_rm)
      3'b000: w_inc = r1_rnd & (r1_stk | r1_mag[0]);
      3'b010: w_inc = r1_sgn & (r1_rnd | r1_stk);
      3'b011: w_inc = ~r1_sgn & (r1_rnd | r1_stk);
      3'b100: w_inc = r1_rnd;
      default: w_inc = 1'b0;
    endcase
  end

  assign w_rmag = {1'b0, r1_mag} + {{INT_W{1'b0}}, w_inc};
  assign w_inx  = r1_rnd | r1_stk;
  assign w_pmax = r1_sgd ? SMAX : '1;
  assign w_nmin = r1_sgd ? SMIN : '0;

  // Range is judged on the rounded magnitude, carry included
  always_comb begin
    if (r1_sgd)
      w_fit = r1_sgn ? (w_rmag <= HALF) : (w_rmag < HALF);
    else
      w_fit = r1_sgn ? (w_rmag == '0) : ~w_rmag[INT_W];
  end

  always_comb begin
    w_res = '0;
    w_iv  = 1'b0;
    w_ie  = 1'b0;
    if (r1_nan) begin
      w_res = w_pmax;
      w_iv  = 1'b1;
    end else if (r1_inf | r1_povf | ~w_fit) begin
      w_res = r1_sgn ? w_nmin : w_pmax;
      w_iv  = 1'b1;
    end else begin
      w_res = r1_sgn ? -w_rmag[INT_W-1:0]
                     : w_rmag[INT_W-1:0];
      w_ie  = w_inx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r2_valid <= 1'b0;
      int_out  <= '0;
      IV       <= 1'b0;
      IE       <= 1'b0;
    end else if (flush) begin
      r2_valid <= 1'b0;
      int_out  <= '0;
      IV       <= 1'b0;
      IE       <= 1'b0;
    end else if (w_adv) begin
      r2_valid <= r1_valid;
      int_out  <= r1_valid ? w_res : '0;
      IV       <= r1_valid & w_iv;
      IE       <= r1_valid & w_ie;
    end
  end

endmodule

// File: tb/tb_ftoi_converter_param.sv
// Bench for ftoi_converter_param: directed plan steps plus a
// randomized stream scored against a real-arithmetic model.
module tb_ftoi_converter_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        valid_in;
  logic        ready_in;
  logic        is_signed;
  logic [2:0]  rm;
  logic [31:0] a;

  logic        ro32, vo32, iv32, ie32;
  logic [31:0] io32;
  logic        ro64, vo64, iv64, ie64;
  logic [63:0] io64;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        iv;
    logic        ie;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  ftoi_converter_param #(.EXP_W(8), .MAN_W(23), .INT_W(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_in(valid_in), .ready_out(ro32),
    .valid_out(vo32), .ready_in(ready_in),
    .is_signed(is_signed), .rm(rm), .a(a),
    .int_out(io32), .IV(iv32), .IE(ie32)
  );

  ftoi_converter_param #(.EXP_W(8), .MAN_W(23), .INT_W(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_in(valid_in), .ready_out(ro64),
    .valid_out(vo64), .ready_in(ready_in),
    .is_signed(is_signed), .rm(rm), .a(a),
    .int_out(io64), .IV(iv64), .IE(ie64)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact value as a real, then IEEE rounding and range rules
  function automatic void ref32(input logic [31:0] f,
                                input logic sg,
                                input logic [2:0] md,
                                output logic [31:0] res,
                                output logic iv,
                                output logic ie);
    int     ex;
    longint mn, li;
    logic   neg, up, odd, ok;
    real    mag, fl, fr, r;
    ex  = int'(f[30:23]);
    mn  = longint'(f[22:0]);
    neg = f[31];
    res = 32'h0;
    iv  = 1'b0;
    ie  = 1'b0;
    if (ex == 255) begin
      iv  = 1'b1;
      if (mn != 0 || !neg)
        res = sg ? 32'h7FFFFFFF : 32'hFFFFFFFF;
      else
        res = sg ? 32'h80000000 : 32'h0;
      return;
    end
    if (ex == 0)
      mag = real'(mn) * 2.0 ** (-149);
    else
      mag = real'(mn + 64'd8388608) * 2.0 ** (ex - 150);
    fl  = $floor(mag);
    fr  = mag - fl;
    odd = ($floor(fl / 2.0) * 2.0 != fl);
    case (md)
      3'd0: up = (fr > 0.5) || (fr == 0.5 && odd);
      3'd2: up = neg && fr > 0.0;
      3'd3: up = !neg && fr > 0.0;
      3'd4: up = fr >= 0.5;
      default: up = 1'b0;
    endcase
    r = fl + (up ? 1.0 : 0.0);
    if (sg)
      ok = neg ? (r <= 2.0 ** 31) : (r <= 2.0 ** 31 - 1.0);
    else
      ok = neg ? (r == 0.0) : (r <= 2.0 ** 32 - 1.0);
    if (!ok) begin
      iv = 1'b1;
      if (neg) res = sg ? 32'h80000000 : 32'h0;
      else     res = sg ? 32'h7FFFFFFF : 32'hFFFFFFFF;
    end else begin
      li  = longint'(r);
      res = neg ? 32'(-li) : 32'(li);
      ie  = fr > 0.0;
    end
  endfunction

  function automatic logic [31:0] rnd_f();
    logic [31:0] sp [9] = '{
      32'h7F800000, 32'hFF800000, 32'h7FC00000,
      32'h00000000, 32'h80000000, 32'h3F000000,
      32'hBF000000, 32'h4F000000, 32'hCF000000
    };
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return sp[$urandom_range(0, 8)];
    if (k == 1) return $urandom;
    if (k == 2)
      return {1'($urandom_range(0, 1)),
              8'($urandom_range(0, 126)),
              23'($urandom)};
    return {1'($urandom_range(0, 1)),
            8'($urandom_range(120, 162)),
            23'($urandom)};
  endfunction

  logic [31:0] g32;
  logic        g32iv, g32ie;
  logic [63:0] g64;
  logic        g64iv, g64ie;
  int          glat;

  task automatic run1(input logic [31:0] f,
                      input logic s,
                      input logic [2:0] m);
    @(negedge clk);
    a = f; is_signed = s; rm = m;
    valid_in = 1'b1; ready_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    glat = 1;
    while (!vo32 && glat < 8) begin
      @(negedge clk);
      glat++;
    end
    g32 = io32; g32iv = iv32; g32ie = ie32;
    g64 = io64; g64iv = iv64; g64ie = ie64;
  endtask

  task automatic d(input string tag, input logic [31:0] f,
                   input logic s, input logic [2:0] m,
                   input logic [31:0] er,
                   input logic eiv, input logic eie);
    run1(f, s, m);
    chk({tag, "_lat"}, 64'(glat), 64'd2);
    chk(tag, 64'(g32), 64'(er));
    chk({tag, "_flags"}, {62'd0, g32iv, g32ie},
        {62'd0, eiv, eie});
  endtask

  task automatic d64(input string tag, input logic [31:0] f,
                     input logic [63:0] er,
                     input logic eiv, input logic eie);
    run1(f, 1'b1, 3'b000);
    chk(tag, g64, er);
    chk({tag, "_flags"}, {62'd0, g64iv, g64ie},
        {62'd0, eiv, eie});
  endtask

  logic        got_acc, last_ro, p_stall;
  logic [31:0] p_int;
  logic        p_iv, p_ie;
  int          n_pop;

  task automatic cyc(input logic vin, input logic [31:0] f,
                     input logic s, input logic [2:0] m,
                     input logic rdy);
    exp_t        e;
    logic [31:0] rr;
    logic        ri, re;
    @(negedge clk);
    valid_in = vin; a = f; is_signed = s;
    rm = m; ready_in = rdy;
    #1;
    if (p_stall)
      chk("stall_hold", {29'd0, vo32, iv32, ie32, io32},
          {29'd0, 1'b1, p_iv, p_ie, p_int});
    if (vo32 && ready_in) begin
      chk("out_expected", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("res", 64'(io32), 64'(e.res));
        chk("flags", {62'd0, iv32, ie32},
            {62'd0, e.iv, e.ie});
        n_pop++;
      end
    end
    if (!vo32)
      chk("idle_flags", {62'd0, iv32, ie32}, 64'd0);
    got_acc = vin && ro32;
    last_ro = ro32;
    if (got_acc) begin
      ref32(f, s, m, rr, ri, re);
      sbq.push_back('{res: rr, iv: ri, ie: re});
    end
    p_stall = vo32 && !ready_in;
    p_int = io32; p_iv = iv32; p_ie = ie32;
  endtask

  logic [31:0] hs [4] = '{
    32'h40200000, 32'hC0200000,
    32'h4EFFFFFF, 32'h3F400000
  };

  initial begin
    int idx;
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0;
    ready_in = 1'b0; is_signed = 1'b0; rm = 3'b000; a = 32'h0;
    p_stall = 1'b0; n_pop = 0;
    repeat (2) @(negedge clk);
    chk("rst_out32", {29'd0, vo32, iv32, ie32, io32}, 64'd0);
    chk("rst_out64", {61'd0, vo64, iv64, ie64}, 64'd0);
    chk("rst_int64", io64, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_vo", 64'(vo32), 64'd0);
    chk("post_rst_ro", 64'(ro32), 64'd1);

    d("p1_rne", 32'h40200000, 1, 3'd0, 32'd2, 0, 1);
    d("p1_rmm", 32'h40200000, 1, 3'd4, 32'd3, 0, 1);
    d("p1_rup", 32'h40200000, 1, 3'd3, 32'd3, 0, 1);
    d("p1_rtz", 32'h40200000, 1, 3'd1, 32'd2, 0, 1);
    d("p1_rdn", 32'hC0200000, 1, 3'd2, 32'hFFFFFFFD, 0, 1);
    d("p1_rm7", 32'h40200000, 1, 3'd7, 32'd2, 0, 1);
    d("p2_min", 32'hCF000000, 1, 3'd0, 32'h80000000, 0, 0);
    d("p2_ovf", 32'h4F000000, 1, 3'd0, 32'h7FFFFFFF, 1, 0);
    d("p2_big", 32'h4EFFFFFF, 1, 3'd0, 32'h7FFFFF80, 0, 0);
    d("p3_u2g", 32'h4F000000, 0, 3'd0, 32'h80000000, 0, 0);
    d("p3_umx", 32'h4F7FFFFF, 0, 3'd0, 32'hFFFFFF00, 0, 0);
    d("p3_uh", 32'hBF000000, 0, 3'd0, 32'h0, 0, 1);
    d("p3_uq", 32'hBF400000, 0, 3'd0, 32'h0, 1, 0);
    d("p3_uqz", 32'hBF400000, 0, 3'd1, 32'h0, 0, 1);
    d("p3_uinf", 32'h7F800000, 0, 3'd0, 32'hFFFFFFFF, 1, 0);
    d("p4_qnan", 32'h7FC00000, 1, 3'd0, 32'h7FFFFFFF, 1, 0);
    d("p4_snan", 32'h7F800001, 1, 3'd0, 32'h7FFFFFFF, 1, 0);
    d("p4_ninf", 32'hFF800000, 0, 3'd0, 32'h0, 1, 0);
    d("p4_ninfs", 32'hFF800000, 1, 3'd0, 32'h80000000, 1, 0);
    d("p4_sub", 32'h00000001, 1, 3'd3, 32'd1, 0, 1);
    d("p4_nzero", 32'h80000000, 1, 3'd0, 32'h0, 0, 0);
    d("p4_nsub", 32'h80000001, 1, 3'd3, 32'h0, 0, 1);
    d64("p6_ovf", 32'h5F000000, 64'h7FFFFFFFFFFFFFFF, 1, 0);
    d64("p6_2p32", 32'h4F800000, 64'h0000000100000000, 0, 0);
    d64("p6_min", 32'hDF000000, 64'h8000000000000000, 0, 0);

    // Back-to-back with the consumer stalled for 3 cycles
    sbq.delete();
    n_pop = 0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      cyc(idx < 4, hs[idx < 4 ? idx : 0], 1'b1, 3'b000, c >= 3);
      if (c <= 1) chk("hs_acc", 64'(got_acc), 64'd1);
      if (c == 2) chk("hs_ready_drop", 64'(last_ro), 64'd0);
      if (got_acc) idx++;
    end
    chk("hs_accepted", 64'(idx), 64'd4);
    chk("hs_all_out", 64'(n_pop), 64'd4);
    chk("hs_empty", 64'(sbq.size()), 64'd0);

    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 9) < 7, rnd_f(),
          1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)),
          $urandom_range(0, 3) != 0);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 32'h0, 1'b0, 3'b000, 1'b1);
    chk("rand_drained", 64'(sbq.size()), 64'd0);

    @(negedge clk);
    a = 32'h40400000; is_signed = 1'b1; rm = 3'b000;
    valid_in = 1'b1; ready_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("fl_pre", 64'(vo32), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    chk("fl_vo", 64'(vo32), 64'd0);
    chk("fl_data", {30'd0, io32, iv32, ie32}, 64'd0);
    @(negedge clk);
    chk("fl_s1", 64'(vo32), 64'd0);
    @(negedge clk);
    chk("fl_s1b", 64'(vo32), 64'd0);

    @(negedge clk);
    a = 32'h4EFFFFFF; valid_in = 1'b1; ready_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("rs_pre", 64'(vo32), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rs_async32", {29'd0, vo32, iv32, ie32, io32}, 64'd0);
    chk("rs_async64", {61'd0, vo64, iv64, ie64}, 64'd0);
    chk("rs_int64", io64, 64'd0);
    @(negedge clk);
    reset = 1'b0; valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rs_quiet", {62'd0, vo32, vo64}, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ftoi_converter_param.md
Name: ftoi_converter_param

Overview:
Parametrised pipelined float-to-integer converter. It supports any IEEE-style binary float format (EXP_W/MAN_W) and any integer width (INT_W), in both signed and unsigned modes. It takes packed operands and classifies them internally, detects range overflow after rounding rather than against fixed constants, and uses a two-stage valid/ready pipeline with stall and flush. It sits in the FPU execute path as the general successor for the FCVT.W/WU/L/LU family.

Parameters:
EXP_W, 8, exponent width; bias = 2^(EXP_W-1)-1
MAN_W, 23, stored mantissa width, without the hidden bit
INT_W, 32, result integer width; legal values 8..64

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
flush  in  1  synchronous pipeline kill
valid_in  in  1  operand valid
ready_out  out  1  converter can accept an operand
valid_out  out  1  result valid
ready_in  in  1  consumer accepts the result
is_signed  in  1  1 = signed result, 0 = unsigned result
rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 behave as RTZ
a  in  1+EXP_W+MAN_W  packed float {sgn, exp, man}
int_out  out  INT_W  result (registered)
IV  out  1  invalid flag
IE  out  1  inexact flag

Behaviour:
- Reset: valid_out=0, int_out=0, IV=0, IE=0. All internal valid bits and data registers are cleared.
- flush: clears both stage valids and the output data on the next edge; it takes priority over accept. A transfer in the same cycle is discarded.
- Pipeline: S1 register, then S2/output register. Latency is exactly 2 cycles from accept to valid_out with no stall.
- Handshakes:
  - ready_out = !s1_valid || !s2_valid || ready_in.
  - S1 advances into S2 when !s2_valid || ready_in.
  - An input is accepted when valid_in && ready_out.
  - Full throughput is 1 result per cycle; a bubble-free stall holds both stages.
  - int_out, IV and IE are stable while valid_out && !ready_in.
- Stage 1 (combinational, then registered):
  - Classify the input:
    - exp all 1s with man != 0 -> NaN (sNaN and qNaN are treated identically).
    - exp all 1s with man = 0 -> inf.
    - exp = 0 -> zero or subnormal. Hidden bit is 0 and the effective unbiased exponent is 1-bias.
  - Unbiased exponent e. If e >= INT_W, set the pre-overflow flag.
  - Otherwise, right-shift {hidden, man} aligned so the MSB equals 2^e into an INT_W+2 field {int, round, sticky-collect}.
  - Shift amounts >= INT_W+MAN_W+2 saturate to all-zero magnitude with sticky = |mantissa.
  - Register: magnitude, round bit, sticky bit, sign, rm, is_signed, class bits, pre-overflow.
- Stage 2 (rounding, range check, negate; result registered to outputs):
  - Round increment rules:
    - RNE: round && (sticky || lsb).
    - RMM: round.
    - RUP: !sgn && (round || sticky).
    - RDN: sgn && (round || sticky).
    - RTZ: never.
  - Rounded magnitude is INT_W+1 bits, keeping the carry.
  - inexact = round || sticky.
- Range limits:
  - signed: positive <= 2^(INT_W-1)-1; negative magnitude <= 2^(INT_W-1).
  - unsigned: positive <= 2^INT_W-1; negative valid only if the rounded magnitude is 0.
- Results, in priority order:
  - NaN -> max positive (signed 0111..1, unsigned 1..1), IV=1, IE=0.
  - +inf, pre-overflow positive, or out-of-range positive -> max positive, IV=1, IE=0.
  - -inf, pre-overflow negative, or out-of-range negative -> signed 1000..0, unsigned 0, IV=1, IE=0.
  - Zero or ±subnormal rounding to 0 -> 0, IV=0, IE=inexact. There is never a -0 result.
  - Otherwise -> result = sgn ? -mag : mag, IV=0, IE=inexact.
- IV and IE are single-cycle-per-result qualifiers: they are meaningful only when valid_out=1 and are 0 otherwise.
- Reset asserted mid-operation drops all in-flight results immediately; nothing is emitted after reset.

Test Plan:
1. FP32 -> INT32, signed: 0x40200000 (2.5) gives RNE 2 IE=1, RMM 3, RUP 3, RTZ 2. 0xC0200000 (-2.5) with RDN gives 0xFFFFFFFD IE=1.
2. Signed limits: 0xCF000000 -> 0x80000000 IV=0 IE=0. 0x4F000000 -> 0x7FFFFFFF IV=1 IE=0. 0x4EFFFFFF -> 0x7FFFFF80 flags 0.
3. Unsigned:
   - 0x4F000000 -> 0x80000000.
   - 0x4F7FFFFF -> 0xFFFFFF00.
   - 0xBF000000 (-0.5) RNE -> 0, IE=1, IV=0.
   - 0xBF400000 (-0.75) RNE -> 0, IV=1, IE=0.
   - 0xBF400000 RTZ -> 0, IE=1.
4. Specials: 0x7FC00000 and 0x7F800001 -> 0x7FFFFFFF IV=1 in signed mode. 0xFF800000 unsigned -> 0 IV=1. 0x00000001 with RUP signed -> 1, IE=1. 0x80000000 -> 0 with flags 0.
5. Handshake: issue 4 back-to-back inputs with ready_in=0 for 3 cycles.
   - ready_out drops after 2 accepts.
   - Results emerge in order with no loss or duplication, 2-cycle latency when unstalled.
   - flush with valid_out=1 -> valid_out=0 next cycle.
   - Async reset mid-stream -> all outputs 0 immediately.
6. INT_W=64 instance: 0x5F000000 signed -> 0x7FFFFFFFFFFFFFFF IV=1. 0x4F800000 -> 0x0000000100000000. 0xDF000000 -> 0x8000000000000000 IV=0.
